// File: rtl/fetch_prefetch.sv
// Instruction fetch unit: issues word reads over a req/ack handshake and queues
// {word, pc} pairs in a small FIFO for the control unit; redirect flushes and restarts.
module fetch_prefetch #(
   parameter int unsigned        DATA_W   = 32,
   parameter int unsigned        ADDR_W   = 9,
   parameter int unsigned        DEPTH    = 4,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic                         Clock,
   input  logic                         Reset,
   input  logic                         Enable,
   input  logic                         Redirect,
   input  logic [ADDR_W-1:0]            RedirectPC,
   output logic                         MemReq,
   output logic [ADDR_W-1:0]            MemAddr,
   input  logic                         MemAck,
   input  logic [DATA_W-1:0]            MemData,
   output logic                         IRValid,
   output logic [DATA_W-1:0]            IR,
   output logic [ADDR_W-1:0]            IRPC,
   input  logic                         IRTake,
   output logic [$clog2(DEPTH+1)-1:0]   Count
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {StIdle, StReq, StDrop} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   fetch_pc;
   logic [ADDR_W-1:0]   req_addr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [PTR_W-1:0]    wr_ptr;
   logic [CNT_W-1:0]    count;
   logic                mem_req;
   logic                ir_valid;
   logic [DATA_W-1:0]   word_mem [DEPTH];
   logic [ADDR_W-1:0]   pc_mem   [DEPTH];

   logic                xfer;
   logic                push;
   logic                pop;
   logic [CNT_W-1:0]    count_next;
   logic [ADDR_W-1:0]   fetch_pc_inc;

   always_comb begin
      xfer         = mem_req & MemAck;
      // Only a transfer issued in REQ carries a wanted word; DROP data is discarded.
      push         = xfer & (state == StReq) & ~Redirect;
      pop          = IRTake & ir_valid & ~Redirect;
      count_next   = count + CNT_W'(push) - CNT_W'(pop);
      fetch_pc_inc = fetch_pc + ADDR_W'(1);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= StIdle;
         fetch_pc <= RESET_PC;
         req_addr <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         mem_req  <= 1'b0;
         ir_valid <= 1'b0;
      end else if (Redirect) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         ir_valid <= 1'b0;
         fetch_pc <= RedirectPC;
         // An issued request cannot be withdrawn, so wait out its ack in DROP.
         if (state != StIdle) begin
            if (xfer) begin
               state   <= StIdle;
               mem_req <= 1'b0;
            end else begin
               state   <= StDrop;
            end
         end
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count    <= count_next;
         ir_valid <= (count_next != '0);
         case (state)
            StIdle: begin
               if (Enable && count < FULL) begin
                  req_addr <= fetch_pc;
                  state    <= StReq;
                  mem_req  <= 1'b1;
               end
            end
            StReq: begin
               if (xfer) begin
                  fetch_pc <= fetch_pc_inc;
                  if (Enable && count_next < FULL) begin
                     req_addr <= fetch_pc_inc;
                  end else begin
                     state   <= StIdle;
                     mem_req <= 1'b0;
                  end
               end
            end
            StDrop: begin
               if (xfer) begin
                  state   <= StIdle;
                  mem_req <= 1'b0;
               end
            end
            default: begin
               state   <= StIdle;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (push && !Reset) begin
         word_mem[wr_ptr] <= MemData;
         pc_mem[wr_ptr]   <= req_addr;
      end
   end

   assign MemReq  = mem_req;
   assign MemAddr = req_addr;
   assign Count   = count;
   assign IRValid = ir_valid;
   assign IR      = ir_valid ? word_mem[rd_ptr] : '0;
   assign IRPC    = ir_valid ? pc_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: directed scenarios plus randomized traffic checked by a
// scoreboard that expects consecutive PCs from the last reset/redirect target.
module tb_fetch_prefetch;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 9;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic              Clock;
   logic              Reset;
   logic              Enable;
   logic              Redirect;
   logic [ADDR_W-1:0] RedirectPC;
   logic              MemReq;
   logic [ADDR_W-1:0] MemAddr;
   logic              MemAck;
   logic [DATA_W-1:0] MemData;
   logic              IRValid;
   logic [DATA_W-1:0] IR;
   logic [ADDR_W-1:0] IRPC;
   logic              IRTake;
   logic [CNT_W-1:0]  Count;

   fetch_prefetch #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .RESET_PC (9'h000)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Enable     (Enable),
      .Redirect   (Redirect),
      .RedirectPC (RedirectPC),
      .MemReq     (MemReq),
      .MemAddr    (MemAddr),
      .MemAck     (MemAck),
      .MemData    (MemData),
      .IRValid    (IRValid),
      .IR         (IR),
      .IRPC       (IRPC),
      .IRTake     (IRTake),
      .Count      (Count)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
      return 32'h100 + 32'(a);
   endfunction

   // Memory: word = 0x100 + addr, ack after a programmable number of wait cycles.
   int wait_cnt  = 0;
   int ack_delay = 0;
   int rnd_delay = 0;
   bit rand_mode = 1'b0;

   assign MemData = word_of(MemAddr);
   assign MemAck  = MemReq && (wait_cnt >= (rand_mode ? rnd_delay : ack_delay));

   always @(posedge Clock) begin
      if (MemReq && MemAck) begin
         wait_cnt  <= 0;
         rnd_delay <= int'($urandom_range(0, 3));
      end else if (MemReq) begin
         wait_cnt  <= wait_cnt + 1;
      end else begin
         wait_cnt  <= 0;
      end
   end

   // Scoreboard restart requests from the stimulus side.
   int                restart_gen = 0;
   logic [ADDR_W-1:0] restart_pc  = '0;
   int                n_pops      = 0;

   initial begin : monitor
      logic [ADDR_W-1:0] exp_q[$];
      logic [ADDR_W-1:0] sb_pc;
      logic [ADDR_W-1:0] e;
      logic [ADDR_W-1:0] prev_addr;
      int                seen_gen;
      bit                prev_req, prev_xfer, prev_en, prev_rst;
      sb_pc = '0; seen_gen = 0; prev_addr = '0;
      prev_req = 1'b0; prev_xfer = 1'b0; prev_en = 1'b0; prev_rst = 1'b1;
      forever begin
         @(negedge Clock);
         if (restart_gen != seen_gen) begin
            seen_gen = restart_gen;
            exp_q.delete();
            sb_pc = restart_pc;
         end
         while (exp_q.size() < 4) begin
            exp_q.push_back(sb_pc);
            sb_pc = sb_pc + 9'd1;
         end
         if (!Reset && IRValid && IRTake && !Redirect) begin
            e = exp_q.pop_front();
            n_pops++;
            check("pop_irpc", 32'(IRPC), 32'(e));
            check("pop_ir", IR, word_of(e));
         end
         check("count_le_depth", 32'(Count <= CNT_W'(DEPTH)), 32'd1);
         check("irvalid_vs_count", 32'(IRValid), 32'(Count != '0));
         if (!IRValid) begin
            check("empty_ir", IR, 32'd0);
            check("empty_irpc", 32'(IRPC), 32'd0);
         end
         if (!prev_rst && prev_req && !prev_xfer) begin
            check("req_held", 32'(MemReq), 32'd1);
            check("addr_stable", 32'(MemAddr), 32'(prev_addr));
         end
         if (!prev_rst && !prev_req && !prev_en) check("no_req_disabled", 32'(MemReq), 32'd0);
         prev_req  = MemReq;
         prev_xfer = MemReq && MemAck;
         prev_en   = Enable;
         prev_rst  = Reset;
         prev_addr = MemAddr;
      end
   end

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic restart(input logic [ADDR_W-1:0] pc);
      restart_pc = pc;
      restart_gen++;
   endtask

   task automatic do_reset();
      Reset    = 1'b1;
      Redirect = 1'b0;
      restart(9'h000);
      step();
      Reset    = 1'b0;
   endtask

   task automatic do_redirect(input logic [ADDR_W-1:0] pc);
      Redirect   = 1'b1;
      RedirectPC = pc;
      restart(pc);
      step();
      Redirect   = 1'b0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin : stimulus
      logic [ADDR_W-1:0] addrs[8];
      int n_addr, low, high, maxc, bad;
      Reset = 1'b1; Enable = 1'b0; Redirect = 1'b0; RedirectPC = '0; IRTake = 1'b0;

      // Reset values
      do_reset();
      check("rst_memreq", 32'(MemReq), 32'd0);
      check("rst_count", 32'(Count), 32'd0);
      check("rst_irvalid", 32'(IRValid), 32'd0);
      check("rst_ir", IR, 32'd0);
      check("rst_irpc", 32'(IRPC), 32'd0);
      check("rst_memaddr", 32'(MemAddr), 32'd0);

      // Fill from reset
      Enable = 1'b1;
      do_reset();
      n_addr = 0;
      for (int i = 0; i < 8; i++) begin
         if (MemReq) begin
            if (n_addr < 8) addrs[n_addr] = MemAddr;
            n_addr++;
         end
         step();
      end
      check("fill_nreq", 32'(n_addr), 32'd4);
      for (int i = 0; i < 4; i++) check("fill_addr", 32'(addrs[i]), 32'(i));
      check("fill_memreq", 32'(MemReq), 32'd0);
      check("fill_count", 32'(Count), 32'd4);
      check("fill_ir", IR, 32'h100);
      check("fill_irpc", 32'(IRPC), 32'd0);

      // Streaming
      IRTake = 1'b1;
      do_reset();
      step(); step();
      low = 0; maxc = 0;
      for (int i = 0; i < 40; i++) begin
         if (!MemReq) low++;
         if (int'(Count) > maxc) maxc = int'(Count);
         step();
      end
      check("stream_req_gaps", 32'(low), 32'd0);
      check("stream_count_le2", 32'(maxc <= 2), 32'd1);

      // Redirect during a pending request
      ack_delay = 3;
      do_reset();
      for (int i = 0; i < 200 && !(MemReq && MemAddr == 9'd5 && wait_cnt == 0); i++) step();
      check("drop_reach_addr5", 32'(MemReq && MemAddr == 9'd5), 32'd1);
      do_redirect(9'h040);
      bad = 0;
      for (int i = 0; i < 20 && MemReq; i++) begin
         if (MemAddr != 9'd5) bad++;
         step();
      end
      check("drop_addr_held", 32'(bad), 32'd0);
      check("drop_released", 32'(MemReq), 32'd0);
      for (int i = 0; i < 10 && !MemReq; i++) step();
      check("drop_new_addr", 32'(MemAddr), 32'h040);
      for (int i = 0; i < 30 && !IRValid; i++) step();
      check("drop_first_irpc", 32'(IRPC), 32'h040);
      check("drop_first_ir", IR, 32'h140);
      ack_delay = 0;

      // Redirect coinciding with xfer and take
      IRTake = 1'b0;
      do_reset();
      for (int i = 0; i < 20 && Count != 3'd2; i++) step();
      check("sim_setup_xfer", 32'(MemReq && MemAck && Count == 3'd2), 32'd1);
      IRTake = 1'b1;
      do_redirect(9'h080);
      IRTake = 1'b0;
      check("sim_count", 32'(Count), 32'd0);
      check("sim_irvalid", 32'(IRValid), 32'd0);
      check("sim_idle", 32'(MemReq), 32'd0);
      step();
      check("sim_req", 32'(MemReq), 32'd1);
      check("sim_addr", 32'(MemAddr), 32'h080);

      // Enable drop and address wrap
      Enable = 1'b0;
      do_reset();
      do_redirect(9'h1FE);
      Enable = 1'b1;
      n_addr = 0;
      for (int i = 0; i < 10 && Enable; i++) begin
         if (MemReq) begin
            addrs[n_addr] = MemAddr;
            n_addr++;
            if (n_addr == 3) Enable = 1'b0;
         end
         step();
      end
      check("wrap_nreq", 32'(n_addr), 32'd3);
      check("wrap_addr0", 32'(addrs[0]), 32'h1FE);
      check("wrap_addr1", 32'(addrs[1]), 32'h1FF);
      check("wrap_addr2", 32'(addrs[2]), 32'h000);
      high = 0;
      for (int i = 0; i < 10; i++) begin
         if (MemReq) high++;
         step();
      end
      check("wrap_no_req", 32'(high), 32'd0);
      check("wrap_count", 32'(Count), 32'd3);

      // Reset mid-operation
      Enable = 1'b1;
      IRTake = 1'b0;
      do_reset();
      for (int i = 0; i < 20 && Count != 3'd3; i++) step();
      check("midrst_setup", 32'(MemReq && Count == 3'd3), 32'd1);
      do_reset();
      check("midrst_memreq", 32'(MemReq), 32'd0);
      check("midrst_count", 32'(Count), 32'd0);
      check("midrst_irvalid", 32'(IRValid), 32'd0);
      check("midrst_memaddr", 32'(MemAddr), 32'd0);

      // Randomized traffic
      rand_mode = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         Enable = ($urandom_range(0, 9) != 0);
         IRTake = ($urandom_range(0, 9) < 6);
         if ($urandom_range(0, 299) == 0) do_reset();
         else if ($urandom_range(0, 39) == 0) do_redirect(9'($urandom));
         else step();
      end
      rand_mode = 1'b0;
      check("random_pops_seen", 32'(n_pops > 300), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Instruction fetch and prefetch buffer that sits directly upstream of the control unit. It issues word reads to instruction memory over a level request/acknowledge handshake and queues the returned words with their addresses in a small FIFO. It presents the oldest instruction to the control unit, which consumes it with a one-cycle take strobe. A redirect input (branch or jump) flushes the queue, drops any in-flight read, and restarts fetching at a new address.

## Interface
Parameters:
- DATA_W, 32, instruction word width
- ADDR_W, 9, word address width; PC increments by 1 per word
- DEPTH, 4, FIFO entries; must be a power of two and at least 2
- RESET_PC, 0, fetch address after reset

Ports:
- Clock  in  1  single clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high
- Enable  in  1  allows new memory requests; an outstanding request always completes
- Redirect  in  1  one-cycle strobe: flush and restart at RedirectPC
- RedirectPC  in  ADDR_W  new fetch address
- MemReq  out  1  read request, held until acknowledged
- MemAddr  out  ADDR_W  read address, stable while MemReq=1
- MemAck  in  1  completes the transfer in any cycle where MemReq=1 (may be same cycle)
- MemData  in  DATA_W  read data, valid when MemReq&&MemAck
- IRValid  out  1  FIFO head valid (Count!=0)
- IR  out  DATA_W  head instruction; 0 when IRValid=0
- IRPC  out  ADDR_W  address of head instruction; 0 when IRValid=0
- IRTake  in  1  control unit consumes the head this cycle; ignored when IRValid=0
- Count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Registers:
  - FetchPC: next address to request.
  - ReqAddr: drives MemAddr.
  - FIFO of {word, pc}.
  - State: IDLE, REQ or DROP.
- Definitions:
  - "xfer" = MemReq && MemAck.
  - "pop" = IRTake && IRValid && !Redirect.
  - Count_next = Count + push − pop.
- IDLE (MemReq=0):
  - Enable && Count<DEPTH && !Redirect: ReqAddr←FetchPC, go to REQ.
- REQ (MemReq=1):
  - No xfer: hold ReqAddr.
  - xfer, no Redirect:
    - Push {MemData, ReqAddr}; FetchPC←FetchPC+1.
    - If Enable && Count_next<DEPTH: ReqAddr←FetchPC+1, stay in REQ (back-to-back, 1 word/cycle). Otherwise go to IDLE.
- Redirect (any state):
  - Flush FIFO (Count←0); FetchPC←RedirectPC.
  - Redirect wins over any simultaneous IRTake.
  - IDLE: stay in IDLE.
  - REQ with xfer: discard MemData, go to IDLE.
  - REQ without xfer: go to DROP. The request cannot be withdrawn.
  - DROP: stay in DROP.
- DROP (MemReq=1, MemAddr=ReqAddr unchanged):
  - On xfer: discard data, go to IDLE.
- Never push when full: REQ is entered or held only with space guaranteed.
- PC arithmetic is modulo 2^ADDR_W; FetchPC wraps from all-ones to 0.
- Push and pop in the same cycle are both performed; Count is unchanged.
- Reset values:
  - State=IDLE; FetchPC=ReqAddr=RESET_PC.
  - Count=0, MemReq=0, MemAddr=RESET_PC.
  - IRValid=0, IR=0, IRPC=0.
  - Reset overrides every other input, including mid-request. Memory tolerates request withdrawal on reset.

## Timing
- MemReq, MemAddr, Count and IRValid are registered outputs.
- IR and IRPC are the FIFO head read combinationally from registered storage.
- First request after reset with Enable=1: MemReq=1 in the second cycle after Reset deasserts (IDLE→REQ transition cycle, then REQ).
- Memory data to the control unit: the word pushed on edge N is visible as IRValid=1 in cycle N+1.
- Redirect to the new request: Redirect at edge N gives IDLE in N+1 and MemReq=1 with MemAddr=RedirectPC in N+2. From DROP, the new request starts 2 cycles after the dropped xfer.
- Sustained throughput: 1 word/cycle with zero-wait memory and IRTake held high.

## Test plan
- Fill from reset: Reset 1 cycle, Enable=1, memory acks same cycle with MemData=0x100+addr, IRTake=0.
  - Addresses 0,1,2,3 requested on consecutive cycles.
  - Then MemReq=0, Count=4, IR=0x100, IRPC=0.
- Streaming: same setup with IRTake=1 continuously.
  - MemReq stays high and IRPC increments by 1 every cycle.
  - Count never exceeds 2; no address skipped or duplicated.
- Redirect during pending request: MemAck delayed 3 cycles, Redirect with RedirectPC=0x40 while MemAddr=5.
  - MemAddr held at 5 until acked; that data is never enqueued.
  - Next MemReq has MemAddr=0x40; first IRValid shows IRPC=0x40.
- Simultaneous events: Redirect in the same cycle as a xfer and IRTake with Count=2.
  - Count=0 next cycle; data discarded.
  - Next request is to RedirectPC.
- Enable drop and wrap-around: RESET_PC=0x1FE, Enable deasserted after 3 requests are issued.
  - Addresses 0x1FE, 0x1FF, 0x000 fetched.
  - The outstanding request completes; no further MemReq while Enable=0.
- Reset mid-operation: Reset asserted while in REQ with Count=3.
  - Next cycle: MemReq=0, Count=0, IRValid=0, MemAddr=RESET_PC.
